// File: rtl/uart_rx_hex_display.sv
// uart_rx_hex_display
//   UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) that turns
//   ASCII hex characters into a 6-digit nibble array for the 7-segment scan
//   encoder. Each hex character shifts in as the newest digit. ESC (0x1B)
//   clears the display. Any other correctly framed byte raises char_err.
//
//   Optional build macro: UART_RX_PARITY_EN (adds an even-parity bit before stop)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rxd        serial receive line (idles high, asynchronous to clk)
//   disp_data  six 4-bit digits, [3:0] newest, [23:20] oldest
//   byte_data  last correctly framed byte
//   byte_valid one-cycle pulse when byte_data updates
//   frame_err  one-cycle pulse on bad stop bit (or bad parity)
//   char_err   one-cycle pulse (with byte_valid) when the byte is not hex/ESC
module uart_rx_hex_display #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic [23:0] disp_data,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        char_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  // Counter reload values: the counter counts down to zero, so a reload of
  // N-1 yields a sample N cycles later.
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] DRAIN  = 3'd5;
`endif

  localparam logic [7:0] ASCII_ESC = 8'h1B;

  // Returns {is_hex, nibble} for an ASCII character.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  logic             rxd_p0, rxd_p1, rxd_p2;
  logic             fall;
  logic [2:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_p2;
  logic             done_p3;
  logic             ferr_p3;
  logic [4:0]       dec;
`ifdef UART_RX_PARITY_EN
  logic             par_bad;
`endif

  // ---- stage p0/p1: two-flop synchronizer, p2: edge register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign fall = rxd_p2 & ~rxd_p1;

  // ---- stage p2: frame state machine, samples the synchronized line ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      done_p3  <= 1'b0;
      ferr_p3  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
`endif
    end else begin
      done_p3 <= 1'b0;
      ferr_p3 <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            baud_cnt <= HALF_RELOAD;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else if (!rxd_p1) begin
            state    <= DATA;
            bit_idx  <= '0;
            baud_cnt <= FULL_RELOAD;
          end else begin
            // Line is high again at mid start bit: a glitch, not a frame.
            state <= IDLE;
          end
        end
        DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            baud_cnt <= FULL_RELOAD;
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            par_bad  <= (^shift_p2) ^ rxd_p1;
            baud_cnt <= FULL_RELOAD;
            state    <= STOP;
          end
        end
        DRAIN: begin
          // Parity failed: sit out the rest of the stop bit before re-arming.
          if (baud_cnt != '0) baud_cnt <= baud_cnt - 1'b1;
          else                state    <= IDLE;
        end
`endif
        STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - 1'b1;
          end else begin
            state <= IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              ferr_p3  <= 1'b1;
              baud_cnt <= HALF_RELOAD;
              state    <= DRAIN;
            end else
`endif
            if (rxd_p1) done_p3 <= 1'b1;
            else        ferr_p3 <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data shift register: LSB arrives first, so new bits enter at the top.
  always_ff @(posedge clk) begin
    if (state == DATA && baud_cnt == '0) shift_p2 <= {rxd_p1, shift_p2[7:1]};
  end

  assign dec = hex_decode(shift_p2);

  // ---- stage p3: byte output and display update ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data  <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      char_err   <= 1'b0;
    end else begin
      byte_valid <= done_p3;
      frame_err  <= ferr_p3;
      char_err   <= 1'b0;
      if (done_p3) begin
        byte_data <= shift_p2;
        if (dec[4])                      disp_data <= {disp_data[19:0], dec[3:0]};
        else if (shift_p2 == ASCII_ESC)  disp_data <= '0;
        else                             char_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_hex_display.sv
// Scoreboard bench for uart_rx_hex_display: stimulus pushes the expected
// result of each frame, a monitor pops and compares on every output pulse.
module tb_uart_rx_hex_display;

  localparam int BIT = 50000000 / 115200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [23:0] disp_data;
  logic [7:0]  byte_data;
  logic        byte_valid, frame_err, char_err;

  uart_rx_hex_display dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .disp_data(disp_data), .byte_data(byte_data),
    .byte_valid(byte_valid), .frame_err(frame_err), .char_err(char_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_ferr;
    logic [7:0]  data;
    logic [23:0] disp;
    logic        cerr;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic [23:0] disp, input logic cerr);
    exp_t e;
    e.is_ferr = 1'b0; e.data = d; e.disp = disp; e.cerr = cerr;
    q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [7:0] d, input logic [23:0] disp);
    exp_t e;
    e.is_ferr = 1'b1; e.data = d; e.disp = disp; e.cerr = 1'b0;
    q.push_back(e);
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time(par);
`else
    if (par === 1'bx) rxd = 1'b1;
`endif
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", q.size(), 0);
    q.delete();
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (byte_valid || frame_err || char_err)) begin
      exp_t e;
      check("pulse_exclusive", {30'd0, byte_valid & frame_err, char_err & ~byte_valid}, 0);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got bv=%0d fe=%0d ce=%0d, required no pulse",
                 byte_valid, frame_err, char_err);
      end else begin
        e = q.pop_front();
        check("byte_valid", byte_valid, !e.is_ferr);
        check("frame_err", frame_err, e.is_ferr);
        check("char_err", char_err, e.cerr);
        check("byte_data", byte_data, e.data);
        check("disp_data", disp_data, e.disp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    check("rst_disp_data", disp_data, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_char_err", char_err, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Hex characters shift in as newest digit.
    expect_byte(8'h31, 24'h000001, 0); send_byte(8'h31, 1, ^8'h31);
    expect_byte(8'h32, 24'h000012, 0); send_byte(8'h32, 1, ^8'h32);
    expect_byte(8'h33, 24'h000123, 0); send_byte(8'h33, 1, ^8'h33);
    expect_byte(8'h41, 24'h00123A, 0); send_byte(8'h41, 1, ^8'h41);
    expect_byte(8'h62, 24'h0123AB, 0); send_byte(8'h62, 1, ^8'h62);
    expect_byte(8'h66, 24'h123ABF, 0); send_byte(8'h66, 1, ^8'h66);
    drain();

    // Oldest digit falls off; ESC clears.
    expect_byte(8'h39, 24'h23ABF9, 0); send_byte(8'h39, 1, ^8'h39);
    expect_byte(8'h1B, 24'h000000, 0); send_byte(8'h1B, 1, ^8'h1B);
    drain();

    // Non-hex character keeps display, raises char_err.
    expect_byte(8'h43, 24'h00000C, 0); send_byte(8'h43, 1, ^8'h43);
    expect_byte(8'h47, 24'h00000C, 1); send_byte(8'h47, 1, ^8'h47);
    drain();

    // Bad stop bit: frame_err only, outputs held; next frame recovers.
    expect_ferr(8'h47, 24'h00000C);    send_byte(8'h35, 0, ^8'h35);
    expect_byte(8'h36, 24'h0000C6, 0); send_byte(8'h36, 1, ^8'h36);
    drain();

    // Short low glitch on an idle line must produce nothing.
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_disp_held", disp_data, 24'h0000C6);
    check("glitch_byte_held", byte_data, 8'h36);

    // Reset in the middle of bit 4 abandons the frame.
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b1);
    rxd = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_disp_data", disp_data, 0);
    check("midrst_byte_data", byte_data, 0);
    check("midrst_byte_valid", byte_valid, 0);
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    expect_byte(8'h37, 24'h000007, 0); send_byte(8'h37, 1, ^8'h37);
    drain();

`ifdef UART_RX_PARITY_EN
    // 0x31 has three ones: parity bit 1 makes the frame even.
    expect_byte(8'h31, 24'h000071, 0); send_byte(8'h31, 1, 1'b1);
    expect_ferr(8'h31, 24'h000071);    send_byte(8'h31, 1, 1'b0);
    drain();
`endif

    repeat (20) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
